// File: rtl/tt_pkg.sv
// tt_pkg: shared FSM states, truth-table width helper and canonical test tables
package tt_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction
  localparam logic [15:0] TT_AND4 = 16'h8000;
  localparam logic [15:0] TT_OR4  = 16'hFFFE;
  localparam logic [15:0] TT_XOR4 = 16'h6996;
  localparam logic [15:0] TT_ZERO = 16'h0000;
endpackage

// File: rtl/tt_settle_cnt.sv
// tt_settle_cnt: per-minterm settle counter with terminal count at SETTLE
module tt_settle_cnt #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [3:0] cnt;
  assign tc = cnt == 4'(SETTLE);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 4'd1;
endmodule

// File: rtl/tt_capture.sv
// tt_capture: sequential truth-table reader for small combinational function blocks
module tt_capture
  import tt_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int SETTLE = 1,
  localparam int TT_W = tt_width(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [TT_W-1:0] exp_tt,
  output logic [N_IN-1:0] x,
  input  logic            y,
  output logic            busy,
  output logic            done,
  output logic [TT_W-1:0] tt,
  output logic            tt_valid,
  output logic [N_IN:0]   ones,
  output logic            match
);
  state_t state, nxt;
  logic [TT_W-1:0] exp_q, tt_nxt;
  logic tc, accept, cap, last;
  assign accept = state == IDLE && start;
  assign cap    = state == RUN && tc;
  assign last   = &x;
  assign tt_nxt = {y, tt[TT_W-1:1]};
  assign busy   = state == RUN;
  assign done   = state == DONE;
  tt_settle_cnt #(.SETTLE(SETTLE)) u_settle (
    .clk(clk),
    .rst(rst),
    .clr(accept | cap),
    .en(busy),
    .tc(tc)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE ? (start ? RUN : IDLE) :
          state == RUN  ? (cap && last ? DONE : RUN) : IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      x        <= '0;
      tt       <= '0;
      ones     <= '0;
      match    <= 1'b0;
      tt_valid <= 1'b0;
      exp_q    <= '0;
    end else if (accept) begin
      x        <= '0;
      tt       <= '0;
      ones     <= '0;
      match    <= 1'b0;
      tt_valid <= 1'b0;
      exp_q    <= exp_tt;
    end else if (cap) begin
      tt   <= tt_nxt;
      ones <= ones + {{N_IN{1'b0}}, y};
      x    <= last ? '0 : x + N_IN'(1);
      if (last) begin
        match    <= tt_nxt == exp_q;
        tt_valid <= 1'b1;
      end
    end
endmodule

// File: tb/tb_tt_capture.sv
// tb_tt_capture: randomized self-checking bench with a behavioural truth-table model
module tb_tt_capture;
  import tt_pkg::*;
  localparam int S = 1;
  localparam int W = 16;
  localparam int L = W * (S + 1);
  logic clk, rst, start, y, busy, done, tt_valid, match;
  logic [15:0] exp_tt, tt, f_tt;
  logic [3:0] x;
  logic [4:0] ones;
  int dly;
  logic [3:0] xp [3] = '{default: 4'd0};
  int checks = 0, failures = 0;
  int m_t = -1, m_ones = 0, lat;
  bit m_valid = 0, m_match = 0;
  logic [15:0] m_tt = '0, m_exp = '0, m_pend = '0;

  tt_capture #(.N_IN(4), .SETTLE(S)) dut (
    .clk(clk), .rst(rst), .start(start), .exp_tt(exp_tt), .x(x), .y(y),
    .busy(busy), .done(done), .tt(tt), .tt_valid(tt_valid), .ones(ones), .match(match)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    xp[2] <= xp[1];
    xp[1] <= xp[0];
    xp[0] <= x;
  end
  always_comb y = (dly == 0) ? f_tt[x] : f_tt[xp[dly-1]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, expv);
    end
  endtask

  function automatic logic [15:0] model_tt(input logic [15:0] f, input int d);
    logic [15:0] r;
    for (int k = 0; k < W; k++) begin
      int i;
      i = (k + 1) * (S + 1) - 1 - d;
      r[k] = f[i < 0 ? 0 : i / (S + 1)];
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) begin
      m_t = -1; m_valid = 0; m_tt = '0; m_ones = 0; m_match = 0; m_exp = '0;
    end else if (m_t >= 0 && m_t < L) begin
      m_t++;
      if (m_t == L) begin
        m_valid = 1; m_tt = m_pend; m_ones = $countones(m_pend); m_match = (m_pend == m_exp);
      end
    end else if (m_t == L) m_t = -1;
    else if (start) begin
      m_t = 0; m_valid = 0; m_exp = exp_tt; m_pend = model_tt(f_tt, dly);
    end

  always @(negedge clk) begin
    chk("x", x, (m_t >= 0 && m_t < L) ? m_t / (S + 1) : 0);
    chk("busy", busy, m_t >= 0 && m_t < L);
    chk("done", done, m_t == L);
    chk("tt_valid", tt_valid, m_valid);
    if (m_valid) begin
      chk("tt", tt, m_tt);
      chk("ones", ones, m_ones);
      chk("match", match, m_match);
    end
  end

  task automatic run(input logic [15:0] f, input int d, input logic [15:0] e, input bit spam, input int ab);
    int n;
    @(negedge clk);
    f_tt = f; dly = d; exp_tt = e; start = 1;
    @(negedge clk);
    start = spam; n = 0;
    chk("tt_valid_drop", tt_valid, 0);
    chk("busy_accept", busy, 1);
    while (!done && n < 200) begin
      if (ab >= 0 && n == ab * (S + 1)) begin
        #2 rst = 1;
        #1;
        chk("rst_x", x, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_tt", tt, 0); chk("rst_valid", tt_valid, 0); chk("rst_ones", ones, 0);
        chk("rst_match", match, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 0; start = 0;
        repeat (4) @(negedge clk);
        return;
      end
      @(negedge clk);
      n++;
      if (spam) exp_tt = $urandom;
    end
    chk("latency", n, L);
    lat = n;
    if (spam) begin
      @(negedge clk);
      start = 0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; start = 0; f_tt = '0; dly = 0; exp_tt = '0;
    repeat (3) @(negedge clk);
    chk("reset_x", x, 0); chk("reset_busy", busy, 0); chk("reset_done", done, 0);
    chk("reset_tt", tt, 0); chk("reset_valid", tt_valid, 0); chk("reset_ones", ones, 0);
    chk("reset_match", match, 0);
    rst = 0;
    repeat (2) @(negedge clk);
    run(TT_AND4, 0, 16'h8000, 0, -1);
    chk("and4_lat", lat, 32); chk("and4_tt", tt, 16'h8000); chk("and4_ones", ones, 1); chk("and4_match", match, 1);
    run(TT_XOR4, 0, 16'h6996, 0, -1);
    chk("xor4_tt", tt, 16'h6996); chk("xor4_ones", ones, 8); chk("xor4_match", match, 1);
    run(TT_XOR4, 0, 16'h6997, 0, -1);
    chk("xor4_bad_tt", tt, 16'h6996); chk("xor4_bad_match", match, 0);
    run(TT_ZERO, 0, 16'h0000, 0, -1);
    chk("zero_tt", tt, 16'h0000); chk("zero_ones", ones, 0);
    run(16'hFFFF, 0, 16'hFFFF, 0, -1);
    chk("one_tt", tt, 16'hFFFF); chk("one_ones", ones, 16); chk("one_match", match, 1);
    run(TT_OR4, 0, TT_OR4, 1, -1);
    chk("spam_tt", tt, 16'hFFFE); chk("spam_match", match, 1);
    run(TT_XOR4, 0, TT_XOR4, 0, 9);
    run(TT_XOR4, 0, TT_XOR4, 0, -1);
    chk("post_abort_tt", tt, 16'h6996); chk("post_abort_ones", ones, 8);
    run(TT_OR4, 1, TT_OR4, 0, -1);
    chk("dly1_tt", tt, 16'hFFFE); chk("dly1_match", match, 1);
    run(TT_OR4, 2, TT_OR4, 0, -1);
    chk("dly2_tt", tt, 16'hFFFC); chk("dly2_match", match, 0);
    for (int i = 0; i < 20; i++) begin
      logic [15:0] f, e;
      int d;
      f = 16'($urandom);
      d = $urandom_range(0, 3);
      e = $urandom_range(0, 1) ? model_tt(f, d) : 16'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run(f, d, e, $urandom_range(0, 3) == 0, -1);
    end
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
